// File: rtl/gb_ctrl_pkg.sv
// Shared types and constants for the frame run controller and its AXI-lite writer.
// Holds default frame sizes, core control-register values and FSM encodings.
package gb_ctrl_pkg;

    localparam int unsigned CNT_W       = 19;
    localparam int unsigned DEF_IN_PIX  = 316224;
    localparam int unsigned DEF_OUT_PIX = 307200;

    localparam logic [31:0] AP_START = 32'h1;
    localparam logic [1:0]  AXI_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_BWAIT,
        ST_RUN,
        ST_DONE
    } gb_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_RESP
    } wr_state_e;

    function automatic logic state_is_busy(input gb_state_e s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage

// File: rtl/gb_axil_wr.sv
// Single AXI-lite write: issues AW and W together, lets each drop on its own
// handshake, then waits for B and reports a one-cycle done pulse with the response.
module gb_axil_wr
    import gb_ctrl_pkg::*;
#(
    parameter logic [4:0]  ADDR = 5'h00,
    parameter logic [31:0] DATA = AP_START
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kick,
    output logic        awvalid,
    input  logic        awready,
    output logic [4:0]  awaddr,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    output logic        aw_w_done,
    output logic        wr_done,
    output logic [1:0]  wr_resp,
    output wr_state_e   dbg_state
);

    // valid/ready: a channel transfers on the rising edge where both are high;
    // a raised valid is held with stable payload until that edge.

    wr_state_e state_q, state_d;
    logic      aw_pend_q, aw_pend_d;
    logic      w_pend_q, w_pend_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WR_IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        aw_w_done = 1'b0;
        wr_done   = 1'b0;
        case (state_q)
            WR_IDLE: begin
                if (kick) begin
                    state_d   = WR_ADDR;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                end
            end
            WR_ADDR: begin
                // Each channel retires independently; leave once neither is outstanding.
                if (awready) aw_pend_d = 1'b0;
                if (wready)  w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d   = WR_RESP;
                    aw_w_done = 1'b1;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    state_d = WR_IDLE;
                    wr_done = 1'b1;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    assign awvalid   = aw_pend_q;
    assign wvalid    = w_pend_q;
    assign bready    = (state_q == WR_RESP);
    assign awaddr    = ADDR;
    assign wdata     = DATA;
    assign wr_resp   = wr_done ? bresp : AXI_OKAY;
    assign dbg_state = state_q;

endmodule

// File: rtl/gb_run_ctrl.sv
// Frame run controller: starts the HLS core over AXI-lite, gates the input pixel
// stream for exactly one frame, and audits the core's output TLAST placement.
module gb_run_ctrl
    import gb_ctrl_pkg::*;
#(
    parameter int unsigned IN_PIX    = DEF_IN_PIX,
    parameter int unsigned OUT_PIX   = DEF_OUT_PIX,
    parameter logic [4:0]  CTRL_ADDR = 5'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [7:0]  src_tdata,
    input  logic        src_tvalid,
    output logic        src_tready,
    output logic [7:0]  core_in_tdata,
    output logic        core_in_tvalid,
    input  logic        core_in_tready,
    output logic        core_in_tlast,
    input  logic        core_out_tvalid,
    input  logic        core_out_tready,
    input  logic        core_out_tlast,
    output logic        awvalid,
    input  logic        awready,
    output logic [4:0]  awaddr,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    output gb_state_e   dbg_state,
    output wr_state_e   dbg_wr_state
);

    localparam logic [CNT_W-1:0] IN_MAX   = CNT_W'(IN_PIX);
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_PIX - 1);
    localparam logic [CNT_W-1:0] OUT_MAX  = CNT_W'(OUT_PIX);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_PIX - 1);

    gb_state_e        state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             err_q, err_d;
    logic             kick;
    logic             aw_w_done;
    logic             wr_done;
    logic [1:0]       wr_resp;
    logic             run;
    logic             in_open;
    logic             in_fire;
    logic             out_fire;

    gb_axil_wr #(
        .ADDR (CTRL_ADDR),
        .DATA (AP_START)
    ) u_axil_wr (
        .clk       (clk),
        .rst       (rst),
        .kick      (kick),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .aw_w_done (aw_w_done),
        .wr_done   (wr_done),
        .wr_resp   (wr_resp),
        .dbg_state (dbg_wr_state)
    );

    // Input path is a pure pass-through while the frame still wants pixels.
    assign run            = (state_q == ST_RUN);
    assign in_open        = (in_cnt_q < IN_MAX);
    assign core_in_tdata  = src_tdata;
    assign core_in_tvalid = run && in_open && src_tvalid;
    assign src_tready     = run && in_open && core_in_tready;
    assign core_in_tlast  = core_in_tvalid && (in_cnt_q == IN_LAST);
    assign in_fire        = core_in_tvalid && core_in_tready;
    assign out_fire       = run && core_out_tvalid && core_out_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q;
        kick      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_CFG;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    err_d     = 1'b0;
                    kick      = 1'b1;
                end
            end
            ST_CFG: begin
                if (aw_w_done) state_d = ST_BWAIT;
            end
            ST_BWAIT: begin
                if (wr_done) begin
                    if (wr_resp != AXI_OKAY) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (in_fire) in_cnt_d = in_cnt_q + CNT_W'(1);
                if (out_fire) begin
                    if (out_cnt_q < OUT_MAX) out_cnt_d = out_cnt_q + CNT_W'(1);
                    // Once saturated the index never equals OUT_LAST, so extra TLASTs flag too.
                    if (core_out_tlast != (out_cnt_q == OUT_LAST)) err_d = 1'b1;
                end
                if ((in_cnt_q == IN_MAX) && (out_cnt_q == OUT_MAX)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = state_is_busy(state_q);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gb_run_ctrl.sv
// Self-checking bench for gb_run_ctrl with a 16-pixel input / 4-pixel output frame.
module tb_gb_run_ctrl;
    import gb_ctrl_pkg::*;

    localparam int IN_N  = 16;
    localparam int OUT_N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [7:0]  src_tdata = 8'h00;
    logic        src_tvalid = 1'b0;
    logic        src_tready;
    logic [7:0]  core_in_tdata;
    logic        core_in_tvalid;
    logic        core_in_tready = 1'b0;
    logic        core_in_tlast;
    logic        core_out_tvalid = 1'b0;
    logic        core_out_tready = 1'b0;
    logic        core_out_tlast = 1'b0;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [4:0]  awaddr;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [31:0] wdata;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  bresp = 2'b00;
    gb_state_e   dbg_state;
    wr_state_e   dbg_wr_state;

    gb_run_ctrl #(
        .IN_PIX    (IN_N),
        .OUT_PIX   (OUT_N),
        .CTRL_ADDR (5'h00)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .src_tdata       (src_tdata),
        .src_tvalid      (src_tvalid),
        .src_tready      (src_tready),
        .core_in_tdata   (core_in_tdata),
        .core_in_tvalid  (core_in_tvalid),
        .core_in_tready  (core_in_tready),
        .core_in_tlast   (core_in_tlast),
        .core_out_tvalid (core_out_tvalid),
        .core_out_tready (core_out_tready),
        .core_out_tlast  (core_out_tlast),
        .awvalid         (awvalid),
        .awready         (awready),
        .awaddr          (awaddr),
        .wvalid          (wvalid),
        .wready          (wready),
        .wdata           (wdata),
        .bvalid          (bvalid),
        .bready          (bready),
        .bresp           (bresp),
        .dbg_state       (dbg_state),
        .dbg_wr_state    (dbg_wr_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         aw_dly;
        int         w_dly;
        logic [1:0] bresp_v;
        int         tlast_pos;
        logic       exp_err;
    } frame_vec_t;

    frame_vec_t vecs[6];

    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int aw_cnt, w_cnt, b_cnt, in_seen, src_rdy_seen;
    logic src_hs;
    logic pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_frame();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; in_seen = 0; src_rdy_seen = 0;
        pend = 1'b0;
        exp_q.delete();
    endtask

    // Observe handshakes between edges, then advance to just after the next edge.
    task automatic tick();
        logic [8:0] e;
        @(negedge clk);
        src_hs = src_tvalid && src_tready;
        if (awvalid && awready) aw_cnt++;
        if (wvalid && wready) w_cnt++;
        if (bvalid && bready) b_cnt++;
        if (src_tready) src_rdy_seen++;
        if (core_in_tvalid && core_in_tready) begin
            in_seen++;
            if (exp_q.size() == 0) begin
                check("in_pix_unexpected", 32'(in_seen), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("in_pix", {23'd0, core_in_tlast, core_in_tdata}, {23'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_pixel(input int idx);
        src_tdata  = 8'($urandom_range(0, 255));
        src_tvalid = 1'b1;
        pend       = 1'b1;
        exp_q.push_back({(idx == IN_N - 1), src_tdata});
    endtask

    task automatic do_cfg(input int aw_dly, input int w_dly, input logic [1:0] bresp_v);
        int viol;
        int k;
        viol = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_clears_err", {30'd0, err, done}, 32'd0);
        check("start_state", 32'(dbg_state), 32'(ST_CFG));
        k = 1;
        while (!(aw_cnt == 1 && w_cnt == 1) && k < 12) begin
            awready = (k > aw_dly);
            wready  = (k > w_dly);
            tick();
            if (aw_cnt != 0 && awvalid) viol++;
            if (w_cnt != 0 && wvalid) viol++;
            if (aw_cnt == 0 && !awvalid) viol++;
            if (w_cnt == 0 && !wvalid) viol++;
            k++;
        end
        awready = 1'b0;
        wready  = 1'b0;
        check("cfg_valid_rules", 32'(viol), 32'd0);
        check("bwait_bready", {31'd0, bready}, 32'd1);
        check("bwait_state", 32'(dbg_state), 32'(ST_BWAIT));
        bvalid = 1'b1;
        bresp  = bresp_v;
        k = 0;
        while (b_cnt == 0 && k < 10) begin
            tick();
            k++;
        end
        bvalid = 1'b0;
        bresp  = 2'b00;
        check("b_handshake", 32'(b_cnt), 32'd1);
    endtask

    task automatic finish_run(input int tlast_pos, input logic exp_err);
        int px_sent;
        int out_sent;
        int cyc;
        px_sent = 0; out_sent = 0; cyc = 0;
        while (!done && cyc < 400) begin
            if (!pend && px_sent < IN_N && $urandom_range(0, 3) != 0) begin
                push_pixel(px_sent);
                px_sent++;
            end
            core_in_tready = ($urandom_range(0, 3) != 0);
            if (out_sent < OUT_N && $urandom_range(0, 2) != 0) begin
                core_out_tvalid = 1'b1;
                core_out_tready = 1'($urandom_range(0, 1));
                core_out_tlast  = (out_sent == tlast_pos);
            end else begin
                core_out_tvalid = 1'b0;
                core_out_tready = 1'b0;
                core_out_tlast  = 1'b0;
            end
            tick();
            if (src_hs) begin
                pend = 1'b0;
                src_tvalid = 1'b0;
            end
            if (core_out_tvalid && core_out_tready) out_sent++;
            cyc++;
        end
        core_out_tvalid = 1'b0;
        core_out_tready = 1'b0;
        core_out_tlast  = 1'b0;
        core_in_tready  = 1'b0;
        src_tvalid      = 1'b0;
        check("run_done", {30'd0, done, busy}, 32'd2);
        check("run_err", 32'(err), 32'(exp_err));
        check("run_in_count", 32'(in_seen), 32'(IN_N));
        check("run_out_count", 32'(out_sent), 32'(OUT_N));
        check("run_queue_empty", 32'(exp_q.size()), 32'd0);
        check("run_one_write", {16'(aw_cnt), 16'(w_cnt)}, {16'd1, 16'd1});
        tick();
        check("done_held", {31'd0, done}, 32'd1);
    endtask

    task automatic run_frame(input frame_vec_t v);
        clear_frame();
        do_cfg(v.aw_dly, v.w_dly, v.bresp_v);
        if (v.bresp_v != AXI_OKAY) begin
            push_pixel(0);
            core_in_tready = 1'b1;
            for (int i = 0; i < 6; i++) tick();
            core_in_tready = 1'b0;
            src_tvalid = 1'b0;
            exp_q.delete();
            check("berr_no_input", 32'(src_rdy_seen), 32'd0);
            check("berr_state", 32'(dbg_state), 32'(ST_DONE));
            check("berr_flags", {29'd0, err, done, busy}, 32'b110);
        end else begin
            finish_run(v.tlast_pos, v.exp_err);
        end
    endtask

    initial begin
        vecs[0] = '{aw_dly: 0, w_dly: 0, bresp_v: 2'b00, tlast_pos: 3, exp_err: 1'b0};
        vecs[1] = '{aw_dly: 3, w_dly: 0, bresp_v: 2'b00, tlast_pos: 3, exp_err: 1'b0};
        vecs[2] = '{aw_dly: 0, w_dly: 2, bresp_v: 2'b00, tlast_pos: 3, exp_err: 1'b0};
        vecs[3] = '{aw_dly: 0, w_dly: 0, bresp_v: 2'b00, tlast_pos: 1, exp_err: 1'b1};
        vecs[4] = '{aw_dly: 0, w_dly: 0, bresp_v: 2'b10, tlast_pos: 3, exp_err: 1'b1};
        vecs[5] = '{aw_dly: 1, w_dly: 1, bresp_v: 2'b00, tlast_pos: 3, exp_err: 1'b0};
        src_hs = 1'b0;
        clear_frame();

        // Reset block
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {23'd0, busy, done, err, awvalid, wvalid, bready,
                                src_tready, core_in_tvalid, core_in_tlast}, 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();

        // Cycle-exact configuration with both ready lines held high
        clear_frame();
        awready = 1'b1;
        wready  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("c1_valids", {30'd0, awvalid, wvalid}, 32'b11);
        check("c1_payload", {wdata[26:0], awaddr}, {AP_START[26:0], 5'h00});
        tick();
        check("c2_valids_low", {30'd0, awvalid, wvalid}, 32'b00);
        check("c2_counts", {16'(aw_cnt), 16'(w_cnt)}, {16'd1, 16'd1});
        check("c2_bready", {31'd0, bready}, 32'd1);
        awready = 1'b0;
        wready  = 1'b0;
        tick();
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        check("c4_run", 32'(dbg_state), 32'(ST_RUN));
        check("c4_bready_low", {31'd0, bready}, 32'd0);
        finish_run(3, 1'b0);

        // Table of frames
        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Reset while seven input pixels have been accepted
        clear_frame();
        do_cfg(0, 0, 2'b00);
        core_in_tready = 1'b1;
        for (int k = 0; k < 40 && in_seen < 7; k++) begin
            if (!pend) push_pixel(in_seen);
            tick();
            if (src_hs) pend = 1'b0;
        end
        check("mid_in_count", 32'(in_seen), 32'd7);
        rst = 1'b1;
        #1;
        check("mid_reset_outputs", {23'd0, busy, done, err, awvalid, wvalid, bready,
                                    src_tready, core_in_tvalid, core_in_tlast}, 32'd0);
        check("mid_reset_state", 32'(dbg_state), 32'(ST_IDLE));
        src_tvalid     = 1'b0;
        core_in_tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_frame(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
